// File: rtl/gray_codec_pkg.sv
// gray_codec_pkg: shared slice arithmetic and reference decode for the Gray decoder
package gray_codec_pkg;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
  function automatic int slice_msb(input int w, input int st, input int s);
    return w - 1 - s * ceil_div(w, st);
  endfunction
  function automatic int slice_lsb(input int w, input int st, input int s);
    int l;
    l = w - (s + 1) * ceil_div(w, st);
    return (l < 0) ? 0 : l;
  endfunction
  function automatic logic [31:0] gray_to_bin(input logic [31:0] g, input int w);
    logic [31:0] gm;
    logic [31:0] b;
    gm = (w >= 32) ? g : (g & ((32'd1 << w) - 32'd1));
    b = '0;
    for (int i = 0; i < 32; i++) b[i] = ^(gm >> i);
    return b;
  endfunction
endpackage

// File: rtl/gray_dec_stage.sv
// gray_dec_stage: one pipeline register resolving Gray bits [MSB:LSB] into binary
module gray_dec_stage #(
  parameter int WIDTH = 4,
  parameter int MSB = 3,
  parameter int LSB = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_adv_next,
  output logic             o_adv,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_word
);
  logic r_valid;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] w_word;
  logic w_x;
  assign o_adv = ~r_valid | i_adv_next;
  assign o_valid = r_valid;
  assign o_word = r_word;
  // resolve this slice MSB-first; bits above hold binary, the last one seeds the running XOR
  always_comb begin
    w_word = i_word;
    w_x = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i > MSB) w_x = i_word[i];
      else if (i >= LSB) begin
        w_x = w_x ^ i_word[i];
        w_word[i] = w_x;
      end
    end
  end
  // stage register: loads when advancing, holds while the stage ahead is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_word <= '0;
    end else if (o_adv) begin
      r_valid <= i_valid;
      if (i_valid) r_word <= w_word;
    end
  end
endmodule

// File: rtl/gray_to_binary_decoder.sv
// gray_to_binary_decoder: pipelined Gray-to-binary decoder; GRAY_STEP_CHECK_EN adds a +/-1 step check
module gray_to_binary_decoder
  import gray_codec_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_binary,
  output logic             out_step_err
);
  logic             w_valid [0:STAGES];
  logic [WIDTH-1:0] w_word  [0:STAGES];
  logic             w_adv   [0:STAGES];
  assign w_valid[0] = in_valid;
  assign w_word[0] = in_gray;
  assign w_adv[STAGES] = out_ready;
  assign in_ready = w_adv[0];
  assign out_valid = w_valid[STAGES];
  assign out_binary = w_word[STAGES];
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    gray_dec_stage #(
      .WIDTH(WIDTH),
      .MSB(slice_msb(WIDTH, STAGES, s)),
      .LSB(slice_lsb(WIDTH, STAGES, s))
    ) u_stage (
      .clk(clk),
      .rst_n(rst_n),
      .i_valid(w_valid[s]),
      .i_word(w_word[s]),
      .i_adv_next(w_adv[s+1]),
      .o_adv(w_adv[s]),
      .o_valid(w_valid[s+1]),
      .o_word(w_word[s+1])
    );
  end
`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] r_ref;
  logic r_has_ref;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;
  assign w_inc = r_ref + WIDTH'(1);
  assign w_dec = r_ref - WIDTH'(1);
  assign out_step_err = r_has_ref & (out_binary != w_inc) & (out_binary != w_dec) & (out_binary != r_ref);
  // remember the last consumed word so a stalled word is judged against the same reference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref <= '0;
      r_has_ref <= 1'b0;
    end else if (out_valid & out_ready) begin
      r_ref <= out_binary;
      r_has_ref <= 1'b1;
    end
  end
`else
  assign out_step_err = 1'b0;
`endif
endmodule
